spi_master_arbiter: RTL
=======================

Name: spi_master_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one spi_master between NUM_REQ requesters.
- Each requester asks for a burst of 1..2^LEN_W words. The block drives spi_master start/data_in one word at a time and returns each received word from data_out.
- Per-word watchdog: a hung transfer releases the bus and flags an error.
- Sits between the client logic and spi_master, in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: SPI word width; must equal the spi_master DATA_WIDTH.
- LEN_W, 4: width of each burst-length field; burst = req_len+1 words.
- GAP_CYCLES, 2: idle clk cycles between words inside a burst (0 allowed).
- TIMEOUT_CYCLES, 1024: clk cycles allowed from m_start to m_finish before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester burst request, level
- req_len  in  NUM_REQ*LEN_W  per-requester burst length minus 1; slice i belongs to requester i
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester next TX word; slice i belongs to requester i
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst
- data_ack  out  NUM_REQ  1-cycle pulse: current req_data word consumed
- rsp_data  out  DATA_WIDTH  last received word
- rsp_valid  out  NUM_REQ  1-cycle pulse: rsp_data valid for that requester
- done  out  NUM_REQ  1-cycle pulse: burst completed normally
- timeout_err  out  NUM_REQ  1-cycle pulse: burst aborted by watchdog
- busy  out  1  high whenever state != IDLE
- m_start  out  1  start pulse to spi_master
- m_data_in  out  DATA_WIDTH  TX word to spi_master
- m_finish  in  1  word-complete pulse from spi_master
- m_data_out  in  DATA_WIDTH  RX word from spi_master

Behaviour:
- Reset: all outputs are 0. State goes to IDLE. Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from last+1 with wrap-around.
  - Next cycle: gnt is one-hot, word_cnt <= req_len slice of the winner, go to LOAD. Latency from req to gnt is 1 cycle.
- LOAD (1 cycle):
  - m_data_in <= req_data slice of the winner.
  - m_start=1 and data_ack[winner]=1 in the same cycle.
  - Clear the watchdog timer; go to WAIT.
  - The requester must present the next word by the following LOAD.
- WAIT:
  - Timer increments every cycle.
  - On m_finish: register rsp_data <= m_data_out and pulse rsp_valid[winner] the next cycle.
    - If word_cnt==0, go to DONE.
    - Otherwise word_cnt decrements and the block goes to GAP (or to LOAD if GAP_CYCLES==0).
  - If timer reaches TIMEOUT_CYCLES-1 without m_finish: pulse timeout_err[winner], clear gnt, set last=winner, go to IDLE. No done is issued.
  - m_finish and timeout in the same cycle: m_finish wins.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- DONE (1 cycle): pulse done[winner], clear gnt, set last=winner, go to IDLE.
  - At least 1 IDLE cycle separates two bursts, which keeps spi_master cs_n deasserted between owners.
- req deasserted mid-burst: ignored. The burst runs to completion, and req_len is sampled only at grant.
- m_finish outside WAIT: ignored.
- m_data_in: holds its last value between words; reset value is 0.
- rst asserted mid-burst: state returns to IDLE next edge and all pulses are suppressed. spi_master shares rst, so no handshake is left pending.
- Fairness: with all req bits high, grants rotate 0,1,2,3,0,...

Decomposition:
- Package spi_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD, WAIT, GAP, DONE);
  - a clog2 helper for the timer and GAP counter widths.
- One sub-module, rr_arbiter: parameterised over NUM_REQ. Takes req and last pointer, returns a one-hot winner and its index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single burst: req=0001, len=2, data 0xA5,0x3C,0xF0, MISO loopback slave returns 0x11,0x22,0x33 → three data_ack, three rsp_valid[0] with 0x11,0x22,0x33, then done[0]=1, gnt=0.
- All four req held high, len=0 each → grant order 0,1,2,3,0, one word each, never two grants in a cycle.
- Requester 2 holds req with len=15 → exactly 16 m_start pulses, each 1 + GAP_CYCLES cycles after the previous finish; done[2] after the 16th rsp_valid.
- Stub spi_master never pulses m_finish, TIMEOUT_CYCLES=16 → timeout_err[1] exactly 16 cycles after m_start, no done, busy low next cycle, then a pending req3 is granted.
- rst pulsed in WAIT mid-burst → all outputs 0 next cycle; the next req0 is granted normally with pointer reset.
- req1 dropped after grant with len=1 → both words still transferred and done[1] pulses.

Source files
------------

// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and helpers for the SPI master arbiter / burst sequencer.
package spi_ctrl_pkg;

    // Burst sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bits needed to hold values 0..value-1; never less than 1
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit above the last winner,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    // Scan upward from last+1; the first hit wins, later hits are masked
    always_comb begin
        logic found;
        int   j;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        j          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant,
// per-word burst sequencing with inter-word gap, and a per-word watchdog.
module spi_master_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_W          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            data_ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            timeout_err,
    output logic                          busy,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_data_in,
    input  logic                          m_finish,
    input  logic [DATA_WIDTH-1:0]         m_data_out
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int TMR_W = clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = clog2(GAP_CYCLES + 1);

    state_t                               state, state_nxt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_a;
    logic [NUM_REQ-1:0][LEN_W-1:0]        len_a;
    logic [NUM_REQ-1:0]                   arb_onehot;
    logic [IDX_W-1:0]                     arb_idx;
    logic [IDX_W-1:0]                     win_idx;
    logic [IDX_W-1:0]                     last;
    logic [LEN_W-1:0]                     word_cnt;
    logic [TMR_W-1:0]                     timer;
    logic [GAP_W-1:0]                     gap_cnt;
    logic [DATA_WIDTH-1:0]                tx_q;
    logic                                 timeout_hit;

    // Packed input buses viewed per requester; slice i belongs to requester i
    assign data_a = req_data;
    assign len_a  = req_len;

    // Watchdog fires only when the word has not finished in the same cycle
    assign timeout_hit = (state == ST_WAIT) && !m_finish
                         && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .last       (last),
        .winner     (arb_onehot),
        .winner_idx (arb_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|req) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (m_finish) begin
                    if (word_cnt == '0)       state_nxt = ST_DONE;
                    else if (GAP_CYCLES == 0) state_nxt = ST_LOAD;
                    else                      state_nxt = ST_GAP;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP:  if (int'(gap_cnt) == GAP_CYCLES - 1) state_nxt = ST_LOAD;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe outputs; suppressed while rst is high so a reset cycle emits nothing
    always_comb begin
        m_start     = 1'b0;
        data_ack    = '0;
        done        = '0;
        timeout_err = '0;
        m_data_in   = tx_q;
        busy        = (state != ST_IDLE);
        if (!rst) begin
            if (state == ST_LOAD) begin
                m_start   = 1'b1;
                data_ack  = gnt;
                m_data_in = data_a[win_idx];
            end
            if (state == ST_DONE) done = gnt;
            if (timeout_hit) timeout_err = gnt;
        end
    end

    // Grant, pointer, burst counters and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            win_idx   <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            word_cnt  <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            tx_q      <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt      <= arb_onehot;
                        win_idx  <= arb_idx;
                        word_cnt <= len_a[arb_idx];
                    end
                end
                ST_LOAD: begin
                    tx_q  <= data_a[win_idx];
                    timer <= '0;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (m_finish) begin
                        rsp_data  <= m_data_out;
                        rsp_valid <= gnt;
                        gap_cnt   <= '0;
                        if (word_cnt != '0) word_cnt <= word_cnt - 1'b1;
                    end else if (timeout_hit) begin
                        gnt  <= '0;
                        last <= win_idx;
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt + 1'b1;
                ST_DONE: begin
                    gnt  <= '0;
                    last <= win_idx;
                end
                default: ;
            endcase
        end
    end

endmodule
